// File: rtl/de4_qsys_spi_slave.sv
// de4_qsys_spi_slave
//   SPI responder (mode 0, MSB first, 8-bit frames) with an Avalon-MM
//   register port. SCLK, SS_n and MOSI are oversampled in the clk domain,
//   so SCLK must run at clk/8 or slower.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   SCLK, SS_n, MOSI    SPI inputs from the external master
//   MISO, MISO_oe       SPI output (shift_reg[7]) and its output enable
//   mem_addr            register address: 0 rxdata, 1 txdata, 2 status, 3 control
//   spi_select          chip select for the register port
//   read_n, write_n     active-low strobes, two-cycle accesses
//   data_from_cpu       write data
//   data_to_cpu         registered read data
//   irq                 registered interrupt request
//   dataavailable       RRDY
//   readyfordata        TRDY
module de4_qsys_spi_slave #(
  parameter int         DATABITS    = 8,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELOAD} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic       rd_p1, rd_p2, wr_p1, wr_p2;
  logic [2:0] addr_p1;
  logic [8:0] wdata_p1;
  logic       rd_commit, wr_commit;
  logic       rd_rx, wr_tx, wr_status, wr_ctrl, tx_ok, toe_set;

  logic [7:0] shift_reg, rx_holding, tx_holding, tx_byte, shifted;
  logic [3:0] bitcnt;
  logic       tx_primed, tx_avail;
  logic       rrdy, roe, toe, tur, sse;
  logic [6:0] ctrl;
  logic       reload_pend, reload_tx;
  logic [15:0] status_word, rd_mux;

  logic load, shift, done, abort;
  logic load_idle, load_reload, tx_consume, tur_set;

  logic unused_ok;
  assign unused_ok = ^data_from_cpu[15:9];

  // ---- input synchronisers and edge detect ----
  // SS_n flops reset to the idle (high) level so MISO_oe stays low in reset
  // and no false frame start is seen when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  // ---- CPU port, first cycle: register strobes, address and data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
      wr_p1    <= 1'b0;
      wr_p2    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      rd_p1    <= spi_select & ~read_n;
      rd_p2    <= rd_p1;
      wr_p1    <= spi_select & ~write_n;
      wr_p2    <= wr_p1;
      addr_p1  <= mem_addr;
      wdata_p1 <= data_from_cpu[8:0];
    end
  end

  // Act once per access, on its second cycle.
  assign rd_commit = rd_p1 & ~rd_p2;
  assign wr_commit = wr_p1 & ~wr_p2;
  assign rd_rx     = rd_commit & (addr_p1 == 3'd0);
  assign wr_tx     = wr_commit & (addr_p1 == 3'd1);
  assign wr_status = wr_commit & (addr_p1 == 3'd2);
  assign wr_ctrl   = wr_commit & (addr_p1 == 3'd3);
  assign tx_ok     = wr_tx & ~tx_primed;
  assign toe_set   = wr_tx & tx_primed;

  // A txdata write landing in the same cycle as a load is used directly.
  assign tx_avail = tx_primed | tx_ok;
  assign tx_byte  = tx_primed ? tx_holding : wdata_p1[7:0];
  assign shifted  = {shift_reg[6:0], mosi_s};

  // ---- FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          load       = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          shift = 1'b1;
          if (bitcnt == 4'(DATABITS - 1)) begin
            done       = 1'b1;
            state_next = RELOAD;
          end
        end
      end
      RELOAD: begin
        if (sclk_fall) begin
          load       = 1'b1;
          state_next = ACTIVE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (ss_rise) begin
      state_next = IDLE;
      load       = 1'b0;
      shift      = 1'b0;
      done       = 1'b0;
      abort      = (bitcnt != 4'd0) && (bitcnt < 4'(DATABITS));
    end
  end

  assign load_idle   = load & (state == IDLE);
  assign load_reload = load & (state == RELOAD);

  // A reload happens on the last SCLK fall of every byte, even when the master
  // is about to end the frame. Its bookkeeping (consuming tx_primed or flagging
  // an underrun) is held back until the first bit of that byte really shifts.
  assign tx_consume = (load_idle & tx_avail) | (shift & reload_pend & reload_tx);
  assign tur_set    = (load_idle & ~tx_avail) | (shift & reload_pend & ~reload_tx);

  assign status_word = {7'b0, roe | toe | tur, rrdy, ~tx_primed, sse, toe, roe, tur, 2'b0};

  always_comb begin
    rd_mux = '0;
    case (addr_p1)
      3'd0:    rd_mux = {8'b0, rx_holding};
      3'd2:    rd_mux = status_word;
      3'd3:    rd_mux = {7'b0, ctrl, 2'b0};
      default: rd_mux = '0;
    endcase
  end

  // ---- datapath, status and CPU second cycle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bitcnt      <= '0;
      rx_holding  <= '0;
      tx_holding  <= '0;
      tx_primed   <= 1'b0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tur         <= 1'b0;
      sse         <= 1'b0;
      ctrl        <= '0;
      reload_pend <= 1'b0;
      reload_tx   <= 1'b0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      if (load) begin
        shift_reg <= tx_avail ? tx_byte : DUMMY_BYTE;
        bitcnt    <= '0;
      end else if (shift) begin
        shift_reg <= shifted;
        bitcnt    <= bitcnt + 4'd1;
      end

      if (done) rx_holding <= shifted;

      // A completing frame beats a simultaneous rxdata read.
      if (done)       rrdy <= 1'b1;
      else if (rd_rx) rrdy <= 1'b0;

      // New errors beat a simultaneous status-clear write.
      roe <= (roe & ~wr_status) | (done & rrdy & ~rd_rx);
      toe <= (toe & ~wr_status) | toe_set;
      tur <= (tur & ~wr_status) | tur_set;
      sse <= (sse & ~wr_status) | abort;

      if (tx_ok) tx_holding <= wdata_p1[7:0];
      if (tx_consume) tx_primed <= 1'b0;
      else if (tx_ok) tx_primed <= 1'b1;

      if (load_reload) begin
        reload_pend <= 1'b1;
        reload_tx   <= tx_avail;
      end else if (shift || ss_rise) begin
        reload_pend <= 1'b0;
      end

      if (wr_ctrl)   ctrl        <= wdata_p1[8:2];
      if (rd_commit) data_to_cpu <= rd_mux;

      irq <= |(status_word[8:2] & ctrl);
    end
  end

  assign MISO          = shift_reg[7];
  assign MISO_oe       = ~ss_s;
  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_primed;

endmodule
